// File: rtl/bundler_binarizer.sv
// Scans signed bundle counters one chunk per cycle and thresholds them into a
// binary hypervector, held on a valid/ready port with a clear pulse on accept.
module bundler_binarizer #(
  parameter int HVDimension  = 512,
  parameter int CounterWidth = 8,
  parameter int ChunkWidth   = 64
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [HVDimension-1:0][CounterWidth-1:0]  counter_i,
  input  logic signed [CounterWidth-1:0]            threshold_i,
  input  logic [HVDimension-1:0]                    tie_hv_i,
  input  logic                                      start_i,
  output logic                                      busy_o,
  output logic [HVDimension-1:0]                    hv_o,
  output logic                                      hv_valid_o,
  input  logic                                      hv_ready_i,
  output logic                                      clr_o
);

  localparam int NumChunks = HVDimension / ChunkWidth;
  localparam int IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic bin_bit(
    input logic signed [CounterWidth-1:0] cnt,
    input logic signed [CounterWidth-1:0] thr,
    input logic                           tie
  );
    if (cnt > thr)      return 1'b1;
    else if (cnt < thr) return 1'b0;
    else                return tie;
  endfunction

  state_t                                               state;
  logic [IdxW-1:0]                                      chunk_idx;
  logic signed [CounterWidth-1:0]                       thr_p0;
  logic [NumChunks-1:0][ChunkWidth-1:0]                 hv_p0;

  logic [NumChunks-1:0][ChunkWidth-1:0][CounterWidth-1:0] cnt_view;
  logic [NumChunks-1:0][ChunkWidth-1:0]                 tie_view;
  logic [ChunkWidth-1:0]                                chunk_bits;
  logic                                                 last_chunk;

  // Chunk-major views: element [k][j] is dimension k*ChunkWidth + j.
  assign cnt_view   = counter_i;
  assign tie_view   = tie_hv_i;
  assign last_chunk = (chunk_idx == IdxW'(NumChunks - 1));

  always_comb begin
    chunk_bits = '0;
    for (int j = 0; j < ChunkWidth; j++) begin
      chunk_bits[j] = bin_bit(cnt_view[chunk_idx][j], thr_p0, tie_view[chunk_idx][j]);
    end
  end

  // Stage p0: threshold captured at start, result chunks written during SCAN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      chunk_idx <= '0;
      thr_p0    <= '0;
      hv_p0     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            thr_p0    <= threshold_i;
            chunk_idx <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          hv_p0[chunk_idx] <= chunk_bits;
          if (last_chunk) begin
            chunk_idx <= '0;
            state     <= HOLD;
          end else begin
            chunk_idx <= chunk_idx + 1'b1;
          end
        end
        HOLD: begin
          if (hv_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state != IDLE);
  assign hv_valid_o = (state == HOLD);
  assign clr_o      = (state == HOLD) && hv_ready_i;
  assign hv_o       = hv_p0;

endmodule

// File: tb/tb_bundler_binarizer.sv
// Randomized bench for bundler_binarizer against a per-dimension threshold model.
module tb_bundler_binarizer;

  localparam int HV  = 512;
  localparam int CW  = 8;
  localparam int CHW = 64;
  localparam int NC  = HV / CHW;

  logic                          clk = 1'b0;
  logic                          rst_i;
  logic [HV-1:0][CW-1:0]         counter_i;
  logic signed [CW-1:0]          threshold_i;
  logic [HV-1:0]                 tie_hv_i;
  logic                          start_i;
  logic                          busy_o;
  logic [HV-1:0]                 hv_o;
  logic                          hv_valid_o;
  logic                          hv_ready_i;
  logic                          clr_o;

  int            cnt [HV];
  int            thr_m;
  logic [HV-1:0] tie_m;
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clk = ~clk;

  bundler_binarizer #(.HVDimension(HV), .CounterWidth(CW), .ChunkWidth(CHW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .counter_i  (counter_i),
    .threshold_i(threshold_i),
    .tie_hv_i   (tie_hv_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .hv_o       (hv_o),
    .hv_valid_o (hv_valid_o),
    .hv_ready_i (hv_ready_i),
    .clr_o      (clr_o)
  );

  task automatic chk(input string tag, input logic [HV-1:0] got, input logic [HV-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [HV-1:0] ref_hv();
    logic [HV-1:0] r;
    for (int i = 0; i < HV; i++) begin
      if (cnt[i] > thr_m)      r[i] = 1'b1;
      else if (cnt[i] < thr_m) r[i] = 1'b0;
      else                     r[i] = tie_m[i];
    end
    return r;
  endfunction

  task automatic load();
    for (int i = 0; i < HV; i++) counter_i[i] = CW'(cnt[i]);
    tie_hv_i    = tie_m;
    threshold_i = CW'(thr_m);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < HV; i++) cnt[i] = v;
  endtask

  // One full pass from IDLE with a given number of not-ready HOLD cycles.
  task automatic do_pass(input int delay, input string tag);
    logic [HV-1:0] exp;
    logic          bad_scan;
    load();
    exp        = ref_hv();
    hv_ready_i = (delay == 0);
    start_i    = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "_busy_scan"}, busy_o, 1'b1);
    bad_scan = 1'b0;
    for (int c = 1; c <= NC; c++) begin
      if (hv_valid_o || clr_o || !busy_o) bad_scan = 1'b1;
      start_i     = 1'($urandom);
      threshold_i = CW'(thr_m + 5);
      if (delay != 0) hv_ready_i = (c < NC) ? 1'($urandom) : 1'b0;
      tick();
    end
    chk({tag, "_scan_quiet"}, bad_scan, 1'b0);
    chk({tag, "_valid"}, hv_valid_o, 1'b1);
    chk({tag, "_hv"}, hv_o, exp);
    for (int d = 0; d < delay; d++) begin
      chk({tag, "_hold_valid"}, hv_valid_o, 1'b1);
      chk({tag, "_hold_clr"}, clr_o, 1'b0);
      chk({tag, "_hold_hv"}, hv_o, exp);
      start_i     = 1'($urandom);
      threshold_i = CW'($urandom);
      tick();
    end
    hv_ready_i = 1'b1;
    start_i    = 1'b1;
    #1;
    chk({tag, "_clr_accept"}, clr_o, 1'b1);
    chk({tag, "_hv_accept"}, hv_o, exp);
    tick();
    start_i    = 1'b0;
    hv_ready_i = 1'($urandom);
    #1;
    chk({tag, "_busy_after"}, busy_o, 1'b0);
    chk({tag, "_valid_after"}, hv_valid_o, 1'b0);
    chk({tag, "_clr_after"}, clr_o, 1'b0);
    tick();
    chk({tag, "_no_second_pass"}, busy_o, 1'b0);
    hv_ready_i = 1'b0;
  endtask

  initial begin
    logic          saw_valid;
    logic [HV-1:0] alt;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    hv_ready_i  = 1'b0;
    counter_i   = '0;
    threshold_i = '0;
    tie_hv_i    = '0;
    tick();
    tick();
    chk("rst_hv", hv_o, '0);
    chk("rst_valid", hv_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_clr", clr_o, 1'b0);
    rst_i = 1'b0;
    tick();

    // All +3 with threshold 0, immediate accept.
    fill(3);
    thr_m = 0;
    tie_m = '0;
    do_pass(0, "plus3");
    chk("plus3_ones", hv_o, {HV{1'b1}});

    // Reset mid-cycle with a start pending.
    start_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_hv", hv_o, '0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_valid", hv_valid_o, 1'b0);
    tick();
    start_i = 1'b0;
    rst_i   = 1'b0;
    tick();
    chk("midrst_idle", busy_o, 1'b0);

    // Alternating -1/+1, dim0 = -1.
    for (int i = 0; i < HV; i++) cnt[i] = (i % 2 == 0) ? -1 : 1;
    for (int i = 0; i < HV; i++) alt[i] = (i % 2 == 1);
    thr_m = 0;
    tie_m = {HV{1'b1}};
    do_pass(2, "alt");
    chk("alt_pattern", hv_o, alt);

    // All-equal counters follow the tie vector.
    fill(0);
    tie_m = {64{8'hA5}};
    do_pass(0, "tie");
    chk("tie_copy", hv_o, tie_hv_i);

    // Extremes.
    fill(-128);
    thr_m = 127;
    tie_m = {HV{1'b1}};
    do_pass(1, "ext_lo");
    fill(127);
    thr_m = -128;
    tie_m = '0;
    do_pass(0, "ext_hi");

    // Long backpressure in HOLD.
    for (int i = 0; i < HV; i++) cnt[i] = $urandom_range(0, 255) - 128;
    thr_m = 0;
    tie_m = {8{$urandom, $urandom}};
    do_pass(5, "stall");

    // Reset during SCAN at chunk 3.
    fill(3);
    thr_m = 0;
    load();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_i = 1'b1;
    #1;
    chk("scanrst_hv", hv_o, '0);
    chk("scanrst_busy", busy_o, 1'b0);
    tick();
    rst_i      = 1'b0;
    hv_ready_i = 1'b1;
    saw_valid  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (hv_valid_o || busy_o || clr_o) saw_valid = 1'b1;
      tick();
    end
    chk("scanrst_never_valid", saw_valid, 1'b0);
    hv_ready_i = 1'b0;
    do_pass(0, "after_rst");

    // Randomized passes with frequent ties.
    for (int p = 0; p < 6; p++) begin
      thr_m = $urandom_range(0, 255) - 128;
      tie_m = {8{$urandom, $urandom}};
      for (int i = 0; i < HV; i++) begin
        case ($urandom_range(0, 3))
          0:       cnt[i] = thr_m;
          1:       cnt[i] = (thr_m < 127) ? thr_m + 1 : thr_m;
          2:       cnt[i] = (thr_m > -128) ? thr_m - 1 : thr_m;
          default: cnt[i] = $urandom_range(0, 255) - 128;
        endcase
      end
      do_pass($urandom_range(0, 4), $sformatf("rand%0d", p));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
